// File: rtl/ones_distributor_if.sv
// Request/response bundle for ones_distributor: a k-of-N request in, a serial
// bit stream and the completed parallel frame out.
interface ones_distributor_if #(
    parameter int N = 8
);
    // Handshake: a request transfers on a rising edge where valid_i && ready_o.
    // ready_o depends only on internal state, never on valid_i. A request that
    // is offered while ready_o is low is ignored, not queued.
    logic [$clog2(N+1)-1:0] ones_i;
    logic                   valid_i;
    logic                   ready_o;
    logic                   bit_o;
    logic                   bit_valid_o;
    logic                   frame_last_o;
    logic [N-1:0]           features_o;
    logic                   features_valid_o;

    modport master (
        output ones_i, valid_i,
        input  ready_o, bit_o, bit_valid_o, frame_last_o, features_o, features_valid_o
    );

    modport slave (
        input  ones_i, valid_i,
        output ready_o, bit_o, bit_valid_o, frame_last_o, features_o, features_valid_o
    );
endinterface

// File: rtl/ones_distributor.sv
// Spreads k ones evenly over an N-bit serial frame using an accumulator.
// Define ONES_DISTRIBUTOR_PARALLEL_EN to also capture the frame into features_o.
module ones_distributor #(
    parameter int OUTPUT_FEATURES = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    ones_distributor_if.slave bus,
    output logic [1:0]        state_o
);
    localparam int N  = OUTPUT_FEATURES;
    localparam int KW = $clog2(N + 1);
    localparam int AW = $clog2(2 * N);
    localparam int JW = $clog2(N);

    localparam logic [KW-1:0] N_K    = KW'(N);
    localparam logic [AW:0]   N_S    = (AW + 1)'(N);
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [JW-1:0] j_q, j_d;

    logic [KW-1:0] k_sat;
    logic [AW:0]   sum;
    logic          hit;
    logic          accept;

    assign k_sat  = (bus.ones_i > N_K) ? N_K : bus.ones_i;
    assign sum    = {1'b0, acc_q} + (AW + 1)'(k_q);
    assign hit    = (sum >= N_S);
    assign accept = (state_q == IDLE) && bus.valid_i;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    k_d     = k_sat;
                    acc_d   = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Remainder after emitting a one stays below N, so acc never grows past N-1.
                acc_d = hit ? AW'(sum - N_S) : AW'(sum);
                j_d   = j_q + 1'b1;
                if (j_q == J_LAST) begin
                    j_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            j_q     <= j_d;
        end
    end

    assign bus.ready_o      = (state_q == IDLE);
    assign bus.bit_valid_o  = (state_q == RUN);
    assign bus.bit_o        = (state_q == RUN) && hit;
    assign bus.frame_last_o = (state_q == RUN) && (j_q == J_LAST);
    assign state_o          = state_q;

`ifdef ONES_DISTRIBUTOR_PARALLEL_EN
    logic [N-1:0] features_q, features_d;

    // Cleared on accept so a stale frame never mixes with the new one.
    always_comb begin
        features_d = features_q;
        if (accept) begin
            features_d = '0;
        end else if (state_q == RUN) begin
            features_d[j_q] = hit;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            features_q <= '0;
        end else begin
            features_q <= features_d;
        end
    end

    assign bus.features_o       = features_q;
    assign bus.features_valid_o = (state_q == DONE);
`else
    assign bus.features_o       = '0;
    assign bus.features_valid_o = 1'b0;
`endif
endmodule
